// File: rtl/mcu_bus_pkg.sv
// mcu_bus_pkg: shared FSM encoding and bridge-select tag definitions
package mcu_bus_pkg;
    localparam int TAG_W = 4;
    localparam logic [TAG_W-1:0] TAG_DEF = 4'b1011;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_WRITE, ST_READ} state_t;
endpackage

// File: rtl/mcu_bus_bridge_if.sv
// mcu_bus_bridge_if: MCU multiplexed-AD pins plus the per-channel register port
interface mcu_bus_bridge_if #(
    parameter int AW = 19,
    parameter int DW = 16,
    parameter int NCH = 4
);
    logic ne, nadv, nwe, noe;
    logic [DW-1:0] ad_in;
    logic [AW-DW-1:0] a_hi;
    logic [DW-1:0] ad_out;
    logic ad_oe;
    logic [DW-1:0] wr_data;
    logic [NCH-1:0] wr_stb, rd_stb;
    logic [NCH*DW-1:0] rd_data;
    logic wr_tgl;
    logic [7:0] miss_cnt;
    modport slave (
        input ne, nadv, nwe, noe, ad_in, a_hi, rd_data,
        output ad_out, ad_oe, wr_data, wr_stb, rd_stb, wr_tgl, miss_cnt
    );
    modport master (
        output ne, nadv, nwe, noe, ad_in, a_hi, rd_data,
        input ad_out, ad_oe, wr_data, wr_stb, rd_stb, wr_tgl, miss_cnt
    );
endinterface

// File: rtl/mcu_bus_bridge_sync_edge.sv
// sync_edge: 2-flop synchroniser with a third flop so level changes show up as a one-cycle chg flag
module sync_edge #(
    parameter int W = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] lvl,
    output logic [W-1:0] chg
);
    logic [W-1:0] s1, s2, s3;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= INIT;
            s2 <= INIT;
            s3 <= INIT;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign lvl = s2;
    assign chg = s2 ^ s3;
endmodule

// File: rtl/mcu_bus_bridge.sv
// mcu_bus_bridge: synchronises a multiplexed-AD MCU bus and turns its accesses into
// per-channel one-cycle register strobes, with read data returned on AD
module mcu_bus_bridge
    import mcu_bus_pkg::*;
#(
    parameter int AW = 19,
    parameter int DW = 16,
    parameter int NCH = 4,
    parameter logic [TAG_W-1:0] TAG = TAG_DEF,
    parameter int CH_LSB = 10
) (
    input logic clk,
    input logic rst_n,
    mcu_bus_bridge_if.slave bus
);
    localparam int CW = $clog2(NCH);
    state_t state;
    logic [3:0] lvl, chg;
    logic [AW-1:0] a_s1, a_s2, addr;
    logic [CW-1:0] ch;
    logic [NCH-1:0] sel, rd_pend;
    logic hit, ne_rise, nadv_rise, nwe_fall, nwe_rise, noe_fall, noe_rise, unused_addr;
    sync_edge #(.W(4), .INIT(4'hF)) u_ctl (
        .clk(clk),
        .rst_n(rst_n),
        .d({bus.ne, bus.nadv, bus.nwe, bus.noe}),
        .lvl(lvl),
        .chg(chg)
    );
    assign ne_rise = chg[3] & lvl[3];
    assign nadv_rise = chg[2] & lvl[2];
    assign nwe_fall = chg[1] & ~lvl[1];
    assign nwe_rise = chg[1] & lvl[1];
    assign noe_fall = chg[0] & ~lvl[0];
    assign noe_rise = chg[0] & lvl[0];
    assign hit = addr[AW-1 -: TAG_W] == TAG;
    assign ch = addr[CH_LSB +: CW];
    assign sel = NCH'(1) << ch;
    assign unused_addr = ^addr;
    // AD and A_HI get the same 2-flop delay as the strobes so they line up with the edges
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_s1 <= '0;
            a_s2 <= '0;
        end else begin
            a_s1 <= {bus.a_hi, bus.ad_in};
            a_s2 <= a_s1;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            addr <= '0;
            rd_pend <= '0;
            bus.ad_out <= '0;
            bus.ad_oe <= 1'b0;
            bus.wr_data <= '0;
            bus.wr_stb <= '0;
            bus.rd_stb <= '0;
            bus.wr_tgl <= 1'b0;
            bus.miss_cnt <= '0;
        end else begin
            bus.wr_stb <= '0;
            bus.rd_stb <= rd_pend;
            rd_pend <= '0;
            if (ne_rise) begin
                state <= ST_IDLE;
                bus.ad_oe <= 1'b0;
            end else if (nadv_rise && !lvl[3]) begin
                state <= ST_ADDR;
                addr <= a_s2;
                bus.ad_oe <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: if (nwe_fall || noe_fall) begin
                        state <= nwe_fall ? ST_WRITE : ST_READ;
                        if (!hit)
                            bus.miss_cnt <= bus.miss_cnt + {7'd0, bus.miss_cnt != 8'hFF};
                        if (hit && !nwe_fall) begin
                            bus.ad_out <= bus.rd_data[int'(ch)*DW +: DW];
                            bus.ad_oe <= 1'b1;
                            rd_pend <= sel;
                        end
                    end
                    ST_WRITE: if (nwe_rise) begin
                        state <= ST_IDLE;
                        if (hit) begin
                            bus.wr_stb <= sel;
                            bus.wr_data <= a_s2[DW-1:0];
                            bus.wr_tgl <= ~bus.wr_tgl;
                        end
                    end
                    ST_READ: if (noe_rise) begin
                        state <= ST_IDLE;
                        bus.ad_oe <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mcu_bus_bridge.sv
// tb_mcu_bus_bridge: random and directed MCU bus accesses checked against a transaction-level model
module tb_mcu_bus_bridge;
    localparam int AW = 19;
    localparam int DW = 16;
    localparam int NCH = 4;
    localparam int CH_LSB = 10;
    localparam logic [3:0] TAG = 4'b1011;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int bad = 0;
    logic [NCH-1:0] last_wr_stb, last_rd_stb;
    logic [DW-1:0] last_wr_data;
    logic m_tgl = 1'b0;
    int m_miss = 0;
    logic [DW-1:0] m_out = '0;

    mcu_bus_bridge_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus ();

    mcu_bus_bridge #(.AW(AW), .DW(DW), .NCH(NCH), .TAG(TAG), .CH_LSB(CH_LSB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (|bus.wr_stb) begin
            wr_cnt++;
            last_wr_stb = bus.wr_stb;
            last_wr_data = bus.wr_data;
        end
        if (|bus.rd_stb) begin
            rd_cnt++;
            last_rd_stb = bus.rd_stb;
        end
        if ($countones({bus.wr_stb, bus.rd_stb}) > 1) bad++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    // One complete access; the model updates tgl/miss/read-back value from the address rules
    task automatic run(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic chk);
        logic hit;
        int ch;
        hit = a[AW-1 -: 4] == TAG;
        ch = int'(a[CH_LSB +: 2]);
        clear_mon();
        bus.ne = 1'b0;
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = a;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        if (wr) begin
            bus.ad_in = d;
            bus.nwe = 1'b0;
            hold(6);
            bus.nwe = 1'b1;
            hold(6);
        end else begin
            bus.ad_in = DW'($urandom);
            bus.noe = 1'b0;
            hold(6);
            if (hit) m_out = bus.rd_data[ch*DW +: DW];
            if (chk) begin
                check("rd_oe", 32'(bus.ad_oe), 32'(hit));
                check("rd_out", 32'(bus.ad_out), 32'(m_out));
            end
            bus.noe = 1'b1;
            hold(6);
        end
        bus.ne = 1'b1;
        hold(6);
        if (wr && hit) m_tgl = ~m_tgl;
        if (!hit) m_miss = (m_miss == 255) ? 255 : m_miss + 1;
        if (chk) begin
            check("wr_cnt", wr_cnt, 32'(wr && hit));
            check("rd_cnt", rd_cnt, 32'(!wr && hit));
            if (wr && hit) begin
                check("wr_stb", 32'(last_wr_stb), 32'(1) << ch);
                check("wr_data", 32'(last_wr_data), 32'(d));
            end
            if (!wr && hit) check("rd_stb", 32'(last_rd_stb), 32'(1) << ch);
            check("oe_off", 32'(bus.ad_oe), 0);
            check("wr_tgl", 32'(bus.wr_tgl), 32'(m_tgl));
            check("miss_cnt", 32'(bus.miss_cnt), m_miss);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_oe"}, 32'(bus.ad_oe), 0);
        check({tag, "_out"}, 32'(bus.ad_out), 0);
        check({tag, "_wdata"}, 32'(bus.wr_data), 0);
        check({tag, "_stb"}, 32'({bus.wr_stb, bus.rd_stb}), 0);
        check({tag, "_tgl"}, 32'(bus.wr_tgl), 0);
        check({tag, "_miss"}, 32'(bus.miss_cnt), 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        bus.ne = 1'b1;
        bus.nadv = 1'b1;
        bus.nwe = 1'b1;
        bus.noe = 1'b1;
        bus.ad_in = '0;
        bus.a_hi = '0;
        bus.rd_data = '0;
        hold(3);
        check_reset_vals("rst");
        rst_n = 1'b1;
        hold(3);

        run(1'b1, 19'h5C400, 16'h1234, 1'b1);
        bus.rd_data = {16'hBEEF, 16'h3333, 16'h2222, 16'h1111};
        run(1'b0, 19'h58C00, 16'h0000, 1'b1);
        check("read_beef", 32'(bus.ad_out), 32'hBEEF);
        run(1'b1, 19'h20000, 16'h5555, 1'b1);
        check("first_miss", 32'(bus.miss_cnt), 1);

        // NE raised in the write data phase
        clear_mon();
        bus.ne = 1'b0;
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = 19'h5C400;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        bus.ad_in = 16'hAAAA;
        bus.nwe = 1'b0;
        hold(6);
        bus.ne = 1'b1;
        hold(6);
        bus.nwe = 1'b1;
        hold(6);
        check("ne_abort_wr", wr_cnt, 0);
        check("ne_abort_tgl", 32'(bus.wr_tgl), 32'(m_tgl));

        // NADV re-asserted mid-write restarts at the new address
        clear_mon();
        bus.ne = 1'b0;
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = 19'h58000;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        bus.ad_in = 16'h0BAD;
        bus.nwe = 1'b0;
        hold(6);
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = 19'h58800;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        bus.ad_in = 16'hC0DE;
        bus.nwe = 1'b1;
        hold(6);
        check("nadv_abort", wr_cnt, 0);
        bus.nwe = 1'b0;
        hold(6);
        bus.nwe = 1'b1;
        hold(6);
        bus.ne = 1'b1;
        hold(6);
        m_tgl = ~m_tgl;
        check("restart_cnt", wr_cnt, 1);
        check("restart_stb", 32'(last_wr_stb), 32'b0100);
        check("restart_data", 32'(last_wr_data), 32'hC0DE);
        check("restart_tgl", 32'(bus.wr_tgl), 32'(m_tgl));

        // NE raised mid-read drops AD_OE
        bus.rd_data = {16'h4444, 16'h5A5A, 16'h6666, 16'h7777};
        bus.ne = 1'b0;
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = 19'h58800;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        bus.noe = 1'b0;
        hold(6);
        m_out = 16'h5A5A;
        check("ne_rd_oe_on", 32'(bus.ad_oe), 1);
        bus.ne = 1'b1;
        hold(4);
        check("ne_rd_oe_off", 32'(bus.ad_oe), 0);
        check("ne_rd_out_hold", 32'(bus.ad_out), 32'(m_out));
        bus.noe = 1'b1;
        hold(6);

        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom);
            if ($urandom_range(3) != 0) a[AW-1 -: 4] = TAG;
            bus.rd_data = {$urandom, $urandom};
            run(1'($urandom_range(1)), a, DW'($urandom), 1'b1);
        end

        run(1'b1, 19'h58000, 16'h00A0, 1'b1);
        run(1'b1, 19'h58800, 16'h00A2, 1'b1);

        for (int i = 0; i < 300; i++) begin
            a = AW'($urandom);
            if (a[AW-1 -: 4] == TAG) a[AW-1] = ~a[AW-1];
            run(1'b1, a, DW'($urandom), 1'b0);
        end
        check("miss_sat", 32'(bus.miss_cnt), 255);

        // Reset pulsed in the read data phase
        bus.rd_data = {16'h9999, 16'h8888, 16'h7777, 16'h6666};
        bus.ne = 1'b0;
        bus.nadv = 1'b0;
        {bus.a_hi, bus.ad_in} = 19'h58400;
        hold(6);
        bus.nadv = 1'b1;
        hold(6);
        bus.noe = 1'b0;
        hold(6);
        check("rst_rd_oe_on", 32'(bus.ad_oe), 1);
        rst_n = 1'b0;
        hold(1);
        check_reset_vals("midrst");
        rst_n = 1'b1;
        m_tgl = 1'b0;
        m_miss = 0;
        m_out = '0;
        clear_mon();
        hold(6);
        bus.noe = 1'b1;
        hold(6);
        bus.ne = 1'b1;
        hold(6);
        check("rst_no_rd", rd_cnt, 0);
        check("rst_no_wr", wr_cnt, 0);
        check("rst_oe", 32'(bus.ad_oe), 0);
        run(1'b1, 19'h5C400, 16'h1234, 1'b1);

        check("onehot", bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
